fnorm_arb: RTL
==============

// Module: fnorm_arb
// PURPOSE
//  Shares one pipelined normalizeD unit among NREQ FP requesters (FADD/FMUL/FCVT ports).
//  Round-robin arbitration, one issue per cycle, in-flight id/tag tracking, result routing.
//  Sits between the FP issue ports and the single normalizeD instance in the FP cluster.
// PARAMETERS
//  NREQ  4   number of requesters (2..8)
//  LAT   2   normalizeD latency in cycles, operand-in to res (>=1)
//  TAGW  9   width of requester-supplied op tag
//  DW    82  operand/result width (normalizeD A/res)
// PORTS
//  clk          in   1          clock
//  rst          in   1          reset, asynchronous, active-high
//  req_vld      in   NREQ       request valid per requester
//  req_ready    out  NREQ       one-hot grant; transfer when req_vld&req_ready
//  req_A        in   NREQ*DW    operand per requester
//  req_isDBL    in   NREQ       double format per requester
//  req_isEXT    in   NREQ       extended format per requester
//  req_tag      in   NREQ*TAGW  op tag per requester
//  stall        in   1          global FP stall
//  flush        in   1          kill request
//  flush_mask   in   NREQ       requesters killed by flush
//  nrm_A        out  DW         to normalizeD A
//  nrm_isDBL    out  1          to normalizeD isDBL
//  nrm_isEXT    out  1          to normalizeD isEXT
//  nrm_en       out  1          to normalizeD en (operand valid)
//  nrm_clkEn    out  1          to normalizeD clkEn (= ~stall)
//  nrm_res      in   DW         from normalizeD res
//  rsp_vld      out  1          result valid
//  rsp_id       out  3          winning requester index of result
//  rsp_tag      out  TAGW       tag of result
//  rsp_data     out  DW         result (= nrm_res)
//  busy         out  1          any op in flight
// BEHAVIOUR
//  Reset (async): rr_ptr=0, all pipe valid bits 0; hence req_ready=0, nrm_en=0, rsp_vld=0, busy=0.
//  Eligible[i] = req_vld[i] & ~(flush & flush_mask[i]); no eligible or stall -> no grant, nrm_en=0.
//  Winner: first eligible index scanning rr_ptr, rr_ptr+1, .. mod NREQ; req_ready=onehot(winner).
//  On issue rr_ptr <= (winner+1) mod NREQ; rr_ptr unchanged when no issue.
//  nrm_A/isDBL/isEXT combinationally muxed from winner, same cycle as req_ready; nrm_en=1.
//  Tracking pipe: LAT stages of {vld,id,tag}; stage0 loads issue; shifts only when ~stall.
//  Issue in cycle N (no stall) -> rsp_vld in cycle N+LAT; each stall cycle adds one cycle.
//  rsp_vld = last stage vld & ~stall & ~(flush & flush_mask[id]); rsp_data = nrm_res, no register.
//  Flush: same cycle clears vld of every stage whose id bit set in flush_mask; survivors unaffected.
//  Flush during stall: kill still applied; pipe otherwise frozen.
//  No output backpressure: consumers must accept rsp every valid cycle.
//  isDBL&isEXT both set is illegal input; forwarded unchanged, bench asserts never occurs.
//  busy = OR of all stage vld bits (post-flush, registered view).
// STRUCTURE
//  Package fnorm_pkg: NREQ/LAT/TAGW/DW defaults, typedef fnorm_req_t {A,isDBL,isEXT,tag},
//  typedef fnorm_trk_t {vld,id,tag}.
//  Sub-module rr_pick #(N): eligible vector + ptr -> onehot grant + encoded winner.
//  Top: rr_pick, operand mux, tracking shift register, flush mask logic.
// TESTING
//  Single req0 A=82'h1_0000_0000_0000_0000 isDBL=1 tag=5 -> nrm_en cyc0, rsp_vld id=0 tag=5 cyc2.
//  All 4 req_vld held 8 cycles -> grants 0,1,2,3,0,1,2,3; rsp ids same order, 1 per cycle.
//  rr_ptr=2, only req1 and req3 valid -> req3 granted, rr_ptr becomes 0, next grant req1.
//  Issue req2 cyc0, stall=1 cyc1-3 -> no grants, pipe frozen, rsp for req2 in cyc5.
//  In-flight ids 1,2; flush mask=4'b0010 -> only id2 rsp delivered; req1 ungranted that cycle.
//  rst pulse mid-stream with 2 in flight -> all outputs 0 immediately, no stale rsp after release.

Source files
------------

// File: rtl/fnorm_pkg.sv
// Shared widths and record types for the normalizeD arbiter.
package fnorm_pkg;
    localparam int FN_NREQ = 4;
    localparam int FN_LAT  = 2;
    localparam int FN_TAGW = 9;
    localparam int FN_DW   = 82;
    localparam int FN_IDW  = 3;

    typedef struct packed {
        logic [FN_DW-1:0]   A;
        logic               isDBL;
        logic               isEXT;
        logic [FN_TAGW-1:0] tag;
    } fnorm_req_t;

    typedef struct packed {
        logic               vld;
        logic [FN_IDW-1:0]  id;
        logic [FN_TAGW-1:0] tag;
    } fnorm_trk_t;
endpackage

// File: rtl/fnorm_arb_rr_pick.sv
// Round-robin picker: first eligible index at or after ptr, wrapping mod N.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  elig_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] win_o,
    output logic          any_o
);
    int j;

    always_comb begin
        gnt_o = '0;
        win_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (!any_o && elig_i[PW'(j)]) begin
                any_o           = 1'b1;
                gnt_o[PW'(j)]   = 1'b1;
                win_o           = PW'(j);
            end
        end
    end
endmodule

// File: rtl/fnorm_arb.sv
// Arbitrates NREQ FP requesters onto one pipelined normalizeD unit and routes
// results back by tracking {vld,id,tag} alongside the unit's pipeline.
module fnorm_arb
    import fnorm_pkg::*;
#(
    parameter int NREQ = FN_NREQ,
    parameter int LAT  = FN_LAT,
    parameter int TAGW = FN_TAGW,
    parameter int DW   = FN_DW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_vld,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0][DW-1:0]    req_A,
    input  logic [NREQ-1:0]            req_isDBL,
    input  logic [NREQ-1:0]            req_isEXT,
    input  logic [NREQ-1:0][TAGW-1:0]  req_tag,
    input  logic                       stall,
    input  logic                       flush,
    input  logic [NREQ-1:0]            flush_mask,
    output logic [DW-1:0]              nrm_A,
    output logic                       nrm_isDBL,
    output logic                       nrm_isEXT,
    output logic                       nrm_en,
    output logic                       nrm_clkEn,
    input  logic [DW-1:0]              nrm_res,
    output logic                       rsp_vld,
    output logic [2:0]                 rsp_id,
    output logic [TAGW-1:0]            rsp_tag,
    output logic [DW-1:0]              rsp_data,
    output logic                       busy
);
    localparam int PW = $clog2(NREQ);

    typedef struct packed {
        logic              vld;
        logic [FN_IDW-1:0] id;
        logic [TAGW-1:0]   tag;
    } trk_t;

    logic [NREQ-1:0] elig, gnt;
    logic [PW-1:0]   win, rr_ptr_q, rr_ptr_d;
    logic            any, issue;
    trk_t [LAT-1:0]  trk_q, trk_d;
    logic [LAT-1:0]  kill;

    assign elig = req_vld & ~({NREQ{flush}} & flush_mask);

    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .elig_i (elig),
        .ptr_i  (rr_ptr_q),
        .gnt_o  (gnt),
        .win_o  (win),
        .any_o  (any)
    );

    // rst gates the grant so outputs drop the moment reset asserts.
    assign issue     = any & ~stall & ~rst;
    assign req_ready = issue ? gnt : '0;
    assign nrm_A     = req_A[win];
    assign nrm_isDBL = req_isDBL[win];
    assign nrm_isEXT = req_isEXT[win];
    assign nrm_en    = issue;
    assign nrm_clkEn = ~stall;

    assign rr_ptr_d = !issue                  ? rr_ptr_q :
                      (win == PW'(NREQ - 1))  ? '0       : win + 1'b1;

    always_comb begin
        kill = '0;
        for (int s = 0; s < LAT; s++)
            for (int r = 0; r < NREQ; r++)
                if (flush && flush_mask[r] && trk_q[s].id == FN_IDW'(r))
                    kill[s] = 1'b1;
    end

    // Kills apply every cycle; the shift itself only happens when not stalled.
    always_comb begin
        trk_d = trk_q;
        for (int s = 0; s < LAT; s++)
            trk_d[s].vld = trk_q[s].vld & ~kill[s];
        if (!stall) begin
            trk_d[0] = '{vld: issue, id: FN_IDW'(win), tag: req_tag[win]};
            for (int s = 1; s < LAT; s++) begin
                trk_d[s]     = trk_q[s-1];
                trk_d[s].vld = trk_q[s-1].vld & ~kill[s-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            trk_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            trk_q    <= trk_d;
        end
    end

    assign rsp_vld  = trk_q[LAT-1].vld & ~stall & ~kill[LAT-1];
    assign rsp_id   = trk_q[LAT-1].id;
    assign rsp_tag  = trk_q[LAT-1].tag;
    assign rsp_data = nrm_res;

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < LAT; s++)
            busy = busy | trk_q[s].vld;
    end
endmodule
